pulse_train_gen: RTL

- Programmable pulse-train generator, the next generation of the team's fixed-interval trigger block.
- Period and high-time are run-time inputs in clock cycles. Supports a continuous mode and a counted burst mode.
- Adds start/stop control, busy/done status and an emitted-pulse counter.
- Sits beside timing/IO blocks (ADC conversion strobes, LED/buzzer drive, sensor polling) and is driven by a control FSM or register interface.

---
 rtl/pulse_pkg.sv | 20 ++
 rtl/pulse_phase_counter.sv | 51 +++++
 rtl/pulse_train_gen.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pulse_pkg.sv
// Purpose: shared types and constants for the pulse-train generator.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: FSM state enum, mode encodings, minimum legal period.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  // Smallest period that still leaves one high and one low cycle.
  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/pulse_phase_counter.sv
// Purpose: phase counter 0..period-1 with wrap flag and next-cycle high flag.
// Latency: phase registered; wrap/high_nxt are combinational from phase and controls.
// Backpressure: none; en simply holds the count when low.
//
// Ports:
//   sclk, nrst      - clock, async active-low reset
//   clr             - force phase to 0 at the next edge (priority over en)
//   en              - advance phase at the next edge
//   period, width   - already-clamped configuration
//   wrap            - current phase is period-1
//   high_nxt        - the phase taking effect at the next edge is < width
module pulse_phase_counter #(
  parameter int CNT_W = 32
) (
  input  logic             sclk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] width,
  output logic             wrap,
  output logic             high_nxt
);

  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] phase_nxt;

  assign wrap = (phase == period - CNT_W'(1));

  always_comb begin
    phase_nxt = phase;
    if (clr) begin
      phase_nxt = '0;
    end else if (en) begin
      phase_nxt = wrap ? '0 : phase + CNT_W'(1);
    end
  end

  // Evaluated on the upcoming phase so that a registered pulse_out lines up
  // with the phase value it belongs to.
  assign high_nxt = (phase_nxt < width);

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      phase <= '0;
    end else begin
      phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/pulse_train_gen.sv
// Purpose: programmable pulse-train generator, continuous or counted burst.
// Latency: first pulse_out high in the cycle after the accepting edge; all outputs registered.
// Backpressure: none; start is only honoured in IDLE, stop aborts from any state.
//
// Ports:
//   sclk, nrst                 - clock, async active-low reset
//   start, stop                - begin / abort a train (stop wins)
//   mode                       - 0 continuous, 1 burst
//   period, width, burst_len   - configuration, latched on an accepted start
//   pulse_out, busy, done      - registered pulse train and status
//   pulse_cnt                  - pulses emitted in the current or last train
module pulse_train_gen
  import pulse_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
) (
  input  logic               sclk,
  input  logic               nrst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   width,
  input  logic [BURST_W-1:0] burst_len,
  output logic               pulse_out,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulse_cnt
);

  state_e state_q, state_d;

  logic               mode_q;
  logic [CNT_W-1:0]   period_q;
  logic [CNT_W-1:0]   width_q;
  logic [BURST_W-1:0] burst_len_q;

  logic [CNT_W-1:0]   period_c;
  logic [CNT_W-1:0]   width_c;

  logic               pulse_out_d;
  logic               busy_d;
  logic               done_d;
  logic [BURST_W-1:0] pulse_cnt_d;
  logic               latch_en;
  logic               ctr_clr;
  logic               ctr_en;
  logic               wrap;
  logic               high_nxt;

  // Clamp so every pulse has at least one high and one low cycle.
  always_comb begin
    period_c = (period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period;
    width_c  = width;
    if (width == '0) begin
      width_c = CNT_W'(1);
    end
    if (width_c >= period_c) begin
      width_c = period_c - CNT_W'(1);
    end
  end

  pulse_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase (
    .sclk     (sclk),
    .nrst     (nrst),
    .clr      (ctr_clr),
    .en       (ctr_en),
    .period   (period_q),
    .width    (width_q),
    .wrap     (wrap),
    .high_nxt (high_nxt)
  );

  always_comb begin
    state_d     = state_q;
    pulse_out_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    pulse_cnt_d = pulse_cnt;
    latch_en    = 1'b0;
    ctr_clr     = 1'b0;
    ctr_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          latch_en    = 1'b1;
          ctr_clr     = 1'b1;
          pulse_cnt_d = '0;
          if (mode == MODE_BURST && burst_len == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            // Phase 0 of the first pulse is issued right away; clamped width >= 1.
            state_d     = RUN;
            busy_d      = 1'b1;
            pulse_out_d = 1'b1;
            pulse_cnt_d = BURST_W'(1);
          end
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (wrap && mode_q == MODE_BURST && pulse_cnt == burst_len_q) begin
          // Last pulse has finished its full low phase.
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          ctr_en      = 1'b1;
          busy_d      = 1'b1;
          pulse_out_d = high_nxt;
          if (wrap) begin
            pulse_cnt_d = pulse_cnt + BURST_W'(1);
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      state_q   <= state_d;
      pulse_out <= pulse_out_d;
      busy      <= busy_d;
      done      <= done_d;
      pulse_cnt <= pulse_cnt_d;
    end
  end

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      mode_q      <= MODE_CONT;
      period_q    <= '0;
      width_q     <= '0;
      burst_len_q <= '0;
    end else if (latch_en) begin
      mode_q      <= mode;
      period_q    <= period_c;
      width_q     <= width_c;
      burst_len_q <= burst_len;
    end
  end

endmodule
